hub75_bcm_scheduler: RTL and testbench

Frame sequencer for the HUB75 panel driver, directly upstream of the colour shift-out stage. Walks every row pair and every bit plane of the framebuffer and commands the shift-out stage through its start/ready handshake. After each shift-out completes, drives the panel row address and the active-low output enable with binary-coded-modulation (BCM) weighted on-times, which produces `bpp_p`-bit intensity per colour channel.

---
 rtl/hub75_bcm_scheduler.sv | 146 ++++++++++++++
 tb/tb_hub75_bcm_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 frame sequencer: walks rows and bit planes, hands each plane to the
// shift-out stage, then blanks and lights the row with a BCM-weighted on-time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | stopped, row/bit at 0, settings sampled when leaving
// START     | one-cycle start pulse to the shift-out stage
// WAIT_ACK  | wait for the shift-out stage to drop ready
// WAIT_DONE | wait for ready to return (shift and latch complete)
// BLANK     | OE off dead time, row address already switched
// DISPLAY   | OE on for oe_base << bit cycles
// NEXT      | advance bit/row, pulse frame_done on the frame wrap
module hub75_bcm_scheduler #(
    parameter int hpixel_p     = 64,
    parameter int vpixel_p     = 64,
    parameter int bpp_p        = 8,
    parameter int segments_p   = 2,
    parameter int oe_base_wd_p = 16,
    localparam int rows_p          = vpixel_p / segments_p,
    localparam int row_wd_p        = $clog2(rows_p),
    localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
    localparam int pix_bit_width_p = $clog2(bpp_p)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic [oe_base_wd_p-1:0]    i_oe_base,
    input  logic [7:0]                 i_blank_cycles,
    output logic                       o_tx_start,
    output logic [addr_width_p-1:0]    o_init_addr,
    output logic [pix_bit_width_p-1:0] o_pix_bit,
    input  logic                       i_tx_ready,
    output logic [row_wd_p-1:0]        o_row_addr,
    output logic                       o_oe_n,
    output logic                       o_busy,
    output logic                       o_frame_done
);

    // one shared down-counter serves both the blank and the display phase
    localparam int cnt_wd_p = (oe_base_wd_p + bpp_p > 8) ? oe_base_wd_p + bpp_p : 8;

    typedef enum logic [2:0] {
        IDLE, START, WAIT_ACK, WAIT_DONE, BLANK, DISPLAY, NEXT
    } state_t;

    state_t                     state_q, state_nx;
    logic [row_wd_p-1:0]        row_q;
    logic [pix_bit_width_p-1:0] bit_q;
    logic [oe_base_wd_p-1:0]    oe_base_q;
    logic [7:0]                 blank_q;
    logic [cnt_wd_p-1:0]        cnt_q;
    logic [cnt_wd_p-1:0]        blank_load, disp_load;
    logic                       last_bit, last_row, cnt_tc, shift_done;

    assign last_bit   = (bit_q == pix_bit_width_p'(bpp_p - 1));
    assign last_row   = (row_q == row_wd_p'(rows_p - 1));
    assign cnt_tc     = (cnt_q == '0);
    assign shift_done = (state_q == WAIT_DONE) && i_tx_ready;
    // a blank setting of 0 still costs one BLANK cycle
    assign blank_load = (blank_q == 8'd0) ? '0 : cnt_wd_p'(blank_q - 8'd1);
    assign disp_load  = (oe_base_q == '0) ? '0
                      : (cnt_wd_p'(oe_base_q) << bit_q) - cnt_wd_p'(1);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:      if (i_enable)    state_nx = START;
            START:                      state_nx = WAIT_ACK;
            WAIT_ACK:  if (!i_tx_ready) state_nx = WAIT_DONE;
            WAIT_DONE: if (i_tx_ready)  state_nx = BLANK;
            BLANK:     if (cnt_tc)      state_nx = (oe_base_q != '0) ? DISPLAY : NEXT;
            DISPLAY:   if (cnt_tc)      state_nx = NEXT;
            NEXT:                       state_nx = i_enable ? START : IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // settings capture, plane/row position and phase timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oe_base_q <= '0;
            blank_q   <= '0;
            row_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (state_q == IDLE && i_enable) begin
                oe_base_q <= i_oe_base;
                blank_q   <= i_blank_cycles;
            end

            // position advances as NEXT is entered so START sees the new plane
            if (state_nx == NEXT) begin
                if (last_bit) begin
                    bit_q <= '0;
                    row_q <= last_row ? '0 : row_q + row_wd_p'(1);
                end else begin
                    bit_q <= bit_q + pix_bit_width_p'(1);
                end
            end else if (state_nx == IDLE) begin
                row_q <= '0;
                bit_q <= '0;
            end

            if (shift_done)
                cnt_q <= blank_load;
            else if (state_q == BLANK && cnt_tc)
                cnt_q <= disp_load;
            else if ((state_q == BLANK || state_q == DISPLAY) && !cnt_tc)
                cnt_q <= cnt_q - cnt_wd_p'(1);
        end
    end

    // registered outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_tx_start   <= 1'b0;
            o_init_addr  <= '0;
            o_pix_bit    <= '0;
            o_row_addr   <= '0;
            o_oe_n       <= 1'b1;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_tx_start   <= (state_nx == START);
            o_busy       <= (state_nx != IDLE);
            o_oe_n       <= (state_nx != DISPLAY);
            o_frame_done <= (state_nx == NEXT) && last_bit && last_row;
            if (state_nx == START) begin
                o_init_addr <= addr_width_p'(row_q) * addr_width_p'(hpixel_p);
                o_pix_bit   <= bit_q;
            end
            // row lines only move while OE is off, at the start of BLANK
            if (shift_done)
                o_row_addr <= row_q;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler on a 4x4, 2-bpp, 2-segment panel with a
// shift-out stage model that drops ready for shift_len cycles after start.
module tb_hub75_bcm_scheduler;

    localparam int HP   = 4;
    localparam int VP   = 4;
    localparam int BPP  = 2;
    localparam int SEG  = 2;
    localparam int ROWS = VP / SEG;
    localparam int AW   = $clog2(HP * VP);
    localparam int PW   = $clog2(BPP);
    localparam int RW   = $clog2(ROWS);
    localparam int OEW  = 16;

    logic          clk;
    logic          rst_n;
    logic          i_enable;
    logic [OEW-1:0] i_oe_base;
    logic [7:0]    i_blank_cycles;
    logic          o_tx_start;
    logic [AW-1:0] o_init_addr;
    logic [PW-1:0] o_pix_bit;
    logic          i_tx_ready;
    logic [RW-1:0] o_row_addr;
    logic          o_oe_n;
    logic          o_busy;
    logic          o_frame_done;

    hub75_bcm_scheduler #(
        .hpixel_p(HP), .vpixel_p(VP), .bpp_p(BPP),
        .segments_p(SEG), .oe_base_wd_p(OEW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
        .i_oe_base(i_oe_base), .i_blank_cycles(i_blank_cycles),
        .o_tx_start(o_tx_start), .o_init_addr(o_init_addr),
        .o_pix_bit(o_pix_bit), .i_tx_ready(i_tx_ready),
        .o_row_addr(o_row_addr), .o_oe_n(o_oe_n), .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // shift-out stage model
    int shift_len = 10;
    int shift_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n)               shift_cnt <= 0;
        else if (o_tx_start)      shift_cnt <= shift_len;
        else if (shift_cnt != 0)  shift_cnt <= shift_cnt - 1;
    end
    assign i_tx_ready = (shift_cnt == 0);

    // one record per plane: what was shifted, how it was lit, and how long it took
    typedef struct {
        int addr; int pbit; int on; int blank; int row; int period;
    } plane_t;

    plane_t obs_q[$];
    plane_t exp_q[$];
    plane_t cur;
    bit     open_pl = 0;
    bit     seen_low;
    int     cyc = 0, start_cyc, rise_cyc, fall_cyc;
    int     done_cnt = 0;
    logic [RW-1:0] prev_row;
    logic   prev_oe_n;

    // output monitor plus continuous row/OE safety checks
    always @(negedge clk) begin
        cyc++;
        if (o_frame_done === 1'b1) done_cnt++;
        if (open_pl && (o_tx_start === 1'b1 || o_busy !== 1'b1)) begin
            cur.period = (o_tx_start === 1'b1) ? cyc - start_cyc : -1;
            cur.blank  = (cur.on > 0 && rise_cyc >= 0) ? fall_cyc - rise_cyc - 1 : -1;
            obs_q.push_back(cur);
            open_pl = 0;
        end
        if (o_tx_start === 1'b1) begin
            open_pl   = 1;
            cur.addr  = int'(o_init_addr);
            cur.pbit  = int'(o_pix_bit);
            cur.on    = 0;
            cur.row   = -1;
            start_cyc = cyc;
            rise_cyc  = -1;
            fall_cyc  = -1;
            seen_low  = 0;
        end else if (open_pl) begin
            if (!i_tx_ready)                    seen_low = 1;
            else if (seen_low && rise_cyc < 0)  rise_cyc = cyc;
            if (o_oe_n === 1'b0) begin
                if (cur.on == 0) begin
                    fall_cyc = cyc;
                    cur.row  = int'(o_row_addr);
                end
                cur.on++;
            end
        end
        if (rst_n) begin
            if (!i_tx_ready) check("oe_off_while_shifting", o_oe_n, 1);
            if (o_row_addr !== prev_row)
                check("row_change_with_oe_off", {o_oe_n, prev_oe_n}, 2'b11);
        end
        prev_row  = o_row_addr;
        prev_oe_n = o_oe_n;
    end

    // runs nfr frames with the given settings and compares against exp_q
    task automatic run_frames(input int ob, input int bl, input int len,
                              input int nfr, input string tag);
        int base  = obs_q.size();
        int dbase = done_cnt;
        int seen  = 0;
        int budget = 0;
        @(negedge clk);
        i_oe_base      = OEW'(ob);
        i_blank_cycles = 8'(bl);
        shift_len      = len;
        i_enable       = 1'b1;
        while (seen < nfr && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (o_frame_done === 1'b1) begin
                seen++;
                if (seen == nfr) i_enable = 1'b0;
            end
        end
        check({tag, " frames_seen"}, seen, nfr);
        i_enable = 1'b0;
        budget = 0;
        while (o_busy !== 1'b0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check({tag, " back_to_idle"}, o_busy, 0);
        repeat (3) @(negedge clk);
        check({tag, " planes"}, obs_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            plane_t o = obs_q[base + i];
            plane_t e = exp_q[i];
            check($sformatf("%s p%0d addr", tag, i),   o.addr,   e.addr);
            check($sformatf("%s p%0d bit", tag, i),    o.pbit,   e.pbit);
            check($sformatf("%s p%0d on", tag, i),     o.on,     e.on);
            check($sformatf("%s p%0d blank", tag, i),  o.blank,  e.blank);
            check($sformatf("%s p%0d row", tag, i),    o.row,    e.row);
            check($sformatf("%s p%0d period", tag, i), o.period, e.period);
        end
        check({tag, " frame_done_pulses"}, done_cnt - dbase, nfr);
    endtask

    // reference: each plane is on for oe_base*2^bit, blanked max(blank,1),
    // and repeats every shift + start/ack/next overhead + blank + on cycles
    task automatic build_model(input int ob, input int bl, input int len, input int nfr);
        plane_t p;
        int blank_eff = (bl == 0) ? 1 : bl;
        exp_q.delete();
        for (int f = 0; f < nfr; f++)
            for (int r = 0; r < ROWS; r++)
                for (int b = 0; b < BPP; b++) begin
                    p.addr   = r * HP;
                    p.pbit   = b;
                    p.on     = ob * (1 << b);
                    p.blank  = (p.on > 0) ? blank_eff : -1;
                    p.row    = (p.on > 0) ? r : -1;
                    p.period = len + 3 + blank_eff + p.on;
                    exp_q.push_back(p);
                end
        exp_q[exp_q.size() - 1].period = -1;
    endtask

    typedef struct {
        int ob; int bl; int len; int on0; int on1; int blank; int per0; int per1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        plane_t p;
        int base, budget, found;
        vecs[0] = '{3, 2,   10, 3, 6,  2,   18,  21};
        vecs[1] = '{0, 0,   10, 0, 0,  1,   14,  14};
        vecs[2] = '{1, 5,   4,  1, 2,  5,   13,  14};
        vecs[3] = '{7, 1,   1,  7, 14, 1,   12,  19};
        vecs[4] = '{2, 255, 3,  2, 4,  255, 263, 265};

        rst_n = 1'b0;
        i_enable = 1'b0;
        i_oe_base = '0;
        i_blank_cycles = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // reset values held while disabled
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("rst oe_n", o_oe_n, 1);
            check("rst tx_start", o_tx_start, 0);
            check("rst init_addr", o_init_addr, 0);
            check("rst pix_bit", o_pix_bit, 0);
            check("rst row_addr", o_row_addr, 0);
            check("rst busy", o_busy, 0);
            check("rst frame_done", o_frame_done, 0);
        end

        // table-driven single frames
        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                p.addr   = (i / 2) * HP;
                p.pbit   = i % 2;
                p.on     = (i % 2) ? vecs[v].on1 : vecs[v].on0;
                p.blank  = (p.on > 0) ? vecs[v].blank : -1;
                p.row    = (p.on > 0) ? i / 2 : -1;
                p.period = (i == 3) ? -1 : ((i % 2) ? vecs[v].per1 : vecs[v].per0);
                exp_q.push_back(p);
            end
            run_frames(vecs[v].ob, vecs[v].bl, vecs[v].len, 1, $sformatf("vec%0d", v));
        end

        // randomized back-to-back frames against the reference model
        for (int k = 0; k < 6; k++) begin
            int ob  = int'($urandom_range(0, 20));
            int bl  = int'($urandom_range(0, 12));
            int len = int'($urandom_range(1, 12));
            build_model(ob, bl, len, 2);
            run_frames(ob, bl, len, 2, $sformatf("rnd%0d", k));
        end

        // enable dropped during the display of row 0, bit 1
        base = obs_q.size();
        @(negedge clk);
        i_oe_base = 16'd3;
        i_blank_cycles = 8'd2;
        shift_len = 10;
        i_enable = 1'b1;
        found = 0;
        for (budget = 0; budget < 500 && found == 0; budget++) begin
            @(negedge clk);
            if (o_oe_n === 1'b0 && o_pix_bit === 1'b1 && o_init_addr === 4'd0) found = 1;
        end
        check("drop reached_display", found, 1);
        i_enable = 1'b0;
        for (budget = 0; budget < 500 && o_busy !== 1'b0; budget++) @(negedge clk);
        check("drop back_to_idle", o_busy, 0);
        repeat (3) @(negedge clk);
        check("drop planes", obs_q.size() - base, 2);
        if (obs_q.size() - base >= 2) begin
            check("drop p0 on", obs_q[base].on, 3);
            check("drop p1 bit", obs_q[base + 1].pbit, 1);
            check("drop p1 on", obs_q[base + 1].on, 6);
        end

        // restart: start pulse exactly one cycle after enable, from row 0 bit 0
        i_enable = 1'b1;
        @(negedge clk);
        check("restart tx_start", o_tx_start, 1);
        check("restart init_addr", o_init_addr, 0);
        check("restart pix_bit", o_pix_bit, 0);

        // reset pulled during a display
        found = 0;
        for (budget = 0; budget < 500 && found == 0; budget++) begin
            @(negedge clk);
            if (o_oe_n === 1'b0) found = 1;
        end
        check("midrst reached_display", found, 1);
        rst_n = 1'b0;
        i_enable = 1'b0;
        @(negedge clk);
        check("midrst oe_n", o_oe_n, 1);
        check("midrst busy", o_busy, 0);
        check("midrst tx_start", o_tx_start, 0);
        check("midrst init_addr", o_init_addr, 0);
        check("midrst row_addr", o_row_addr, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst idle", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
